// File: rtl/multiplier2x2.sv
// rtl/multiplier2x2.sv - 2x2 gate-level multiplier with registered product, valid and zero flag
// Optional macro MULTIPLIER2X2_PIPE_EN adds a register stage ahead of the outputs (2-cycle latency).
module multiplier2x2 #(
    parameter int SIGNED_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       in_valid,
    output logic [3:0] c,
    output logic       out_valid,
    output logic       zero
);

    logic       pp00;
    logic       pp01;
    logic       pp10;
    logic       pp11;
    logic       carry1;
    logic [3:0] prod_u;
    logic       borrow;
    logic [1:0] signed_hi;
    logic [3:0] prod;
    logic [3:0] stage_prod;
    logic       stage_valid;

    assign pp00   = a[0] & b[0];
    assign pp01   = a[0] & b[1];
    assign pp10   = a[1] & b[0];
    assign pp11   = a[1] & b[1];
    assign carry1 = pp10 & pp01;

    assign prod_u = {pp11 & carry1, pp11 ^ carry1, pp10 ^ pp01, pp00};

    // Signed result = unsigned product - 4*(a1*b + b1*a) mod 16; that correction
    // term mod 4 is {carry1, c1}, so only the upper two bits need a 2-bit subtract.
    assign borrow    = ~prod_u[2] & prod_u[1];
    assign signed_hi = {prod_u[3] ^ carry1 ^ borrow, prod_u[2] ^ prod_u[1]};

    assign prod = (SIGNED_MODE != 0) ? {signed_hi, prod_u[1:0]} : prod_u;

`ifdef MULTIPLIER2X2_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_prod  <= 4'b0000;
            stage_valid <= 1'b0;
        end else begin
            stage_valid <= in_valid;
            if (in_valid) begin
                stage_prod <= prod;
            end
        end
    end
`else
    assign stage_prod  = prod;
    assign stage_valid = in_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= 4'b0000;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= stage_valid;
            if (stage_valid) begin
                c    <= stage_prod;
                zero <= (stage_prod == 4'b0000);
            end
        end
    end

endmodule

// File: tb/tb_multiplier2x2.sv
// tb/tb_multiplier2x2.sv - scoreboard bench for multiplier2x2, unsigned and signed instances
module tb_multiplier2x2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] a = 2'b00;
    logic [1:0] b = 2'b00;
    logic       in_valid = 1'b0;
    logic [3:0] c_u;
    logic       out_valid_u;
    logic       zero_u;
    logic [3:0] c_s;
    logic       out_valid_s;
    logic       zero_s;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] q_u[$];
    logic [3:0] q_s[$];
    logic [3:0] last_u = 4'h0;
    logic [3:0] last_s = 4'h0;

    // Hand-computed products indexed by {a,b}
    logic [3:0] exp_u [16] = '{4'h0, 4'h0, 4'h0, 4'h0,
                               4'h0, 4'h1, 4'h2, 4'h3,
                               4'h0, 4'h2, 4'h4, 4'h6,
                               4'h0, 4'h3, 4'h6, 4'h9};
    logic [3:0] exp_s [16] = '{4'h0, 4'h0, 4'h0, 4'h0,
                               4'h0, 4'h1, 4'hE, 4'hF,
                               4'h0, 4'hE, 4'h4, 4'h2,
                               4'h0, 4'hF, 4'h2, 4'h1};

    always #5 clk = ~clk;

    multiplier2x2 #(.SIGNED_MODE(0)) dut_u (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .c(c_u), .out_valid(out_valid_u), .zero(zero_u)
    );

    multiplier2x2 #(.SIGNED_MODE(1)) dut_s (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .c(c_s), .out_valid(out_valid_s), .zero(zero_s)
    );

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: pops one expected product per out_valid pulse
    always @(negedge clk) begin
        if (out_valid_u) begin
            if (q_u.size() == 0) begin
                check("unexpected_out_valid_u", {1'b1, c_u}, 5'h00);
            end else begin
                logic [3:0] e;
                e = q_u.pop_front();
                check("product_u", {zero_u, c_u}, {(e == 4'h0), e});
            end
        end
        if (out_valid_s) begin
            if (q_s.size() == 0) begin
                check("unexpected_out_valid_s", {1'b1, c_s}, 5'h00);
            end else begin
                logic [3:0] e;
                e = q_s.pop_front();
                check("product_s", {zero_s, c_s}, {(e == 4'h0), e});
            end
        end
    end

    task automatic issue(input logic [1:0] ai, input logic [1:0] bi, input bit expect_out);
        @(negedge clk);
        a        = ai;
        b        = bi;
        in_valid = 1'b1;
        if (expect_out) begin
            q_u.push_back(exp_u[{ai, bi}]);
            q_s.push_back(exp_s[{ai, bi}]);
            last_u = exp_u[{ai, bi}];
            last_s = exp_s[{ai, bi}];
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_u.size() != 0 || q_s.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q_u.size() != 0 || q_s.size() != 0) begin
            check("drain_timeout", 5'(q_u.size() + q_s.size()), 5'h00);
            q_u.delete();
            q_s.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_u"}, {out_valid_u, zero_u, c_u[2:0]}, 5'b01000);
        check({name, "_s"}, {out_valid_s, zero_s, c_s[2:0]}, 5'b01000);
        check({name, "_c3"}, {3'b000, c_u[3], c_s[3]}, 5'h00);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Zero operands, single pulse
        issue(2'd0, 2'd0, 1'b1);
        idle();
        drain();

        // Back-to-back unsigned sequence 0,3,6,4,9
        issue(2'd0, 2'd3, 1'b1);
        issue(2'd1, 2'd3, 1'b1);
        issue(2'd2, 2'd3, 1'b1);
        issue(2'd2, 2'd2, 1'b1);
        issue(2'd3, 2'd3, 1'b1);
        idle();
        drain();

        // Hold while operands toggle with in_valid low
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 2'(i);
            b = 2'(3 - i);
            check("hold_u", {out_valid_u, c_u}, {1'b0, last_u});
            check("hold_s", {out_valid_s, c_s}, {1'b0, last_s});
            check("hold_zero", {3'b000, zero_u, zero_s}, {3'b000, last_u == 4'h0, last_s == 4'h0});
        end

        // Exhaustive sweep, both instances
        for (int i = 0; i < 16; i++) begin
            issue(2'(i >> 2), 2'(i & 3), 1'b1);
        end
        idle();
        drain();

        // Operation presented during reset is discarded
        @(negedge clk);
        rst      = 1'b1;
        a        = 2'd3;
        b        = 2'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_reset_state("rst_override");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst_override_after");

        // Reset one cycle after issuing 3*3
`ifdef MULTIPLIER2X2_PIPE_EN
        issue(2'd3, 2'd3, 1'b0);
`else
        issue(2'd3, 2'd3, 1'b1);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_reset_state("flush");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("flush_after");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multiplier2x2.md
MULTIPLIER2X2 -- requirements
Module: multiplier2x2

Interface
REQ-001 Parameter: SIGNED_MODE, default 0, 0 = operands and product unsigned, 1 = two's-complement operands and product.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous to clk, active-high.
REQ-004 Port: a  input  2  multiplicand.
REQ-005 Port: b  input  2  multiplier.
REQ-006 Port: in_valid  input  1  a/b sampled as a new operation when high at a rising edge.
REQ-007 Port: c  output  4  registered product a*b.
REQ-008 Port: out_valid  output  1  high for exactly one cycle per accepted operation, aligned with the new c.
REQ-009 Port: zero  output  1  registered flag, high when the current c equals 4'b0000.

Function
REQ-010 Product SHALL be formed from the partial products a[i]&b[j] using bitwise logic and 1-bit half-adder equations, with no behavioural multiply operator:
- c0 = a0&b0
- c1 = a1&b0 ^ a0&b1
- c2 = a1&b1 ^ carry1
- c3 = a1&b1&carry1
- carry1 = a1&b0&a0&b1
REQ-011 With SIGNED_MODE=0, c SHALL equal the unsigned product, range 0..9; 3*3 SHALL give 4'b1001.
REQ-012 With SIGNED_MODE=1, c SHALL equal the 4-bit two's-complement product of the signed operands (range -2..4), e.g. (-1)*(-2)=4'b0010 and (-2)*1=4'b1110.
REQ-013 Base latency SHALL be 1 cycle: operands accepted at edge N appear on c, zero and out_valid after edge N.
REQ-014 When in_valid is low, c and zero SHALL hold their last values and out_valid SHALL be 0.
REQ-015 Back-to-back in_valid SHALL be accepted every cycle, with no stall and no backpressure.
REQ-016 Operand changes while in_valid is low SHALL NOT affect any output.
REQ-017 zero SHALL always be consistent with c in the same cycle.

Reset
REQ-018 When rst is high at a rising edge: c=4'b0000, zero=1, out_valid=0, and all internal pipeline registers cleared.
REQ-019 rst SHALL override in_valid in the same cycle; an operation presented during reset SHALL be discarded.
REQ-020 Reset mid-operation, including with MULTIPLIER2X2_PIPE_EN defined, SHALL flush any in-flight result; no out_valid pulse follows for it.

Configuration
REQ-021 Macro MULTIPLIER2X2_PIPE_EN, when defined, SHALL insert one extra register stage between the partial-product logic and the output registers, including a delayed valid.
REQ-022 With MULTIPLIER2X2_PIPE_EN defined, latency SHALL be 2 cycles, throughput SHALL remain one operation per cycle, and results SHALL be identical to the 1-cycle build.
REQ-023 Without MULTIPLIER2X2_PIPE_EN, latency SHALL be 1 cycle per REQ-013; the port list SHALL be identical in both builds.

Verification
REQ-024 Reset, then a=0, b=0 with in_valid -> c=0, zero=1, single out_valid pulse after latency.
REQ-025 Unsigned sequence (a,b) = (0,3), (1,3), (2,3), (2,2), (3,3) on consecutive valid cycles -> c = 0, 3, 6, 4, 9 on consecutive cycles, with out_valid held high for 5 cycles.
REQ-026 Exhaustive 16-pair sweep in each SIGNED_MODE -> every c matches the reference product modulo 16; zero=1 only for a zero product.
REQ-027 in_valid low while a/b toggle -> c, zero hold and out_valid=0.
REQ-028 Assert rst one cycle after issuing 3*3 with MULTIPLIER2X2_PIPE_EN defined -> c=0, zero=1, no out_valid for the flushed operation.
